// File: rtl/hd44780_line_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hd44780_line_sequencer: snapshots a line of character slots and streams  |
// | one set-DDRAM-address command plus NUM_CHARS data bytes over valid/ready.|
// | Optional macro HD44780_LEADING_BLANK_EN blanks a leading zero in slot 0. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module hd44780_line_sequencer #(
  parameter int NUM_CHARS = 8,
  parameter int START_COL = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [1:0]             i_line_sel,
  input  logic [6*NUM_CHARS-1:0] i_chars,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic                   o_rs,
  output logic [7:0]             o_q,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [3:0] c_LAST_IDX = 4'(NUM_CHARS - 1);
  localparam logic [7:0] c_COL      = 8'(START_COL);
`ifdef HD44780_LEADING_BLANK_EN
  localparam logic       c_LEAD_BLANK = 1'b1;
`else
  localparam logic       c_LEAD_BLANK = 1'b0;
`endif

  generate
    if (NUM_CHARS < 1 || NUM_CHARS > 16 || START_COL < 0 || NUM_CHARS + START_COL > 16) begin : g_param_check
      $error("hd44780_line_sequencer: NUM_CHARS/START_COL out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_CHAR = 2'd2
  } state_t;

  state_t                   r_state;
  logic [3:0]               r_idx;
  logic [6*NUM_CHARS-1:0]   r_chars;
  logic [3:0]               w_next_idx;
  logic [5:0]               w_slot_next;
  logic                     w_hs;

  function automatic logic [7:0] map_char(input logic [5:0] slot, input logic first);
    logic [7:0] ch;
    case (slot[5:4])
      2'b00:   ch = (slot[3:0] <= 4'd9) ? (8'h30 + {4'h0, slot[3:0]}) : 8'h3F;
      2'b01:   ch = slot[0] ? 8'h50 : 8'h41;
      2'b10:   ch = 8'h20;
      default: ch = 8'h3A;
    endcase
    if (c_LEAD_BLANK && first && slot == 6'h00) ch = 8'h20;
    return ch;
  endfunction

  always_comb begin
    w_hs        = o_valid && i_ready;
    w_next_idx  = r_idx + 4'd1;
    w_slot_next = '0;
    for (int k = 0; k < NUM_CHARS; k++) begin
      if (4'(k) == w_next_idx) w_slot_next = r_chars[6*k +: 6];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_chars <= '0;
      o_valid <= 1'b0;
      o_rs    <= 1'b0;
      o_q     <= 8'h00;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle still counts as busy for start requests.
          if (i_start && !o_done) begin
            r_chars <= i_chars;
            r_idx   <= 4'd0;
            o_valid <= 1'b1;
            o_rs    <= 1'b0;
            o_q     <= 8'h80 | ({1'b0, i_line_sel[0], 1'b0, i_line_sel[1], 4'b0000} + c_COL);
            o_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_hs) begin
            r_idx   <= 4'd0;
            o_rs    <= 1'b1;
            o_q     <= map_char(r_chars[5:0], 1'b1);
            r_state <= S_CHAR;
          end
        end
        S_CHAR: begin
          if (w_hs) begin
            if (r_idx == c_LAST_IDX) begin
              o_valid <= 1'b0;
              o_rs    <= 1'b0;
              o_q     <= 8'h00;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= w_next_idx;
              o_q   <= map_char(w_slot_next, 1'b0);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hd44780_line_sequencer.sv
`default_nettype none
// Testbench for hd44780_line_sequencer: directed and randomized line transfers
// checked against a slot-to-byte reference model.
module tb_hd44780_line_sequencer;

  localparam int N = 8;
`ifdef HD44780_LEADING_BLANK_EN
  localparam bit LEAD = 1'b1;
`else
  localparam bit LEAD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, ready;
  logic [1:0]     sel;
  logic [6*N-1:0] chars;
  logic           valid, rs, busy, done;
  logic [7:0]     q;

  logic           b_start, b_ready;
  logic [1:0]     b_sel;
  logic [5:0]     b_chars;
  logic           b_valid, b_rs, b_busy, b_done;
  logic [7:0]     b_q;

  int total = 0;
  int bad   = 0;

  hd44780_line_sequencer #(.NUM_CHARS(N), .START_COL(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_line_sel(sel), .i_chars(chars),
    .i_ready(ready), .o_valid(valid), .o_rs(rs), .o_q(q), .o_busy(busy), .o_done(done)
  );

  hd44780_line_sequencer #(.NUM_CHARS(1), .START_COL(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_line_sel(b_sel), .i_chars(b_chars),
    .i_ready(b_ready), .o_valid(b_valid), .o_rs(b_rs), .o_q(b_q), .o_busy(b_busy), .o_done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_char(input logic [5:0] s, input bit first);
    int kind = int'(s[5:4]);
    int pay  = int'(s[3:0]);
    if (kind == 0) begin
      if (first && LEAD && pay == 0) return 8'h20;
      return (pay <= 9) ? 8'(48 + pay) : 8'h3F;
    end
    if (kind == 1) return (pay % 2 == 1) ? 8'h50 : 8'h41;
    if (kind == 2) return 8'h20;
    return 8'h3A;
  endfunction

  function automatic logic [7:0] ref_addr(input int line, input int col);
    int base [4] = '{128, 192, 144, 208};
    return 8'(base[line] + col);
  endfunction

  task automatic run_a(input logic [1:0] l, input logic [5:0] s [N], input int stall_at,
                       input int stall_len, input bit rnd_stall, input int inject_at,
                       input bit inject_done, input int rst_at);
    logic [7:0] exp_q [$];
    bit         exp_rs [$];
    int         stalls;
    exp_q.push_back(ref_addr(int'(l), 0));
    exp_rs.push_back(1'b0);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(ref_char(s[k], k == 0));
      exp_rs.push_back(1'b1);
      chars[6*k +: 6] = s[k];
    end
    sel   = l;
    start = 1'b1;
    step();
    start = 1'b0;
    sel   = 2'($urandom);
    chars = {$urandom, $urandom};
    for (int b = 0; b <= N; b++) begin
      if (b == rst_at) begin
        rst = 1'b1;
        step();
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        step();
        chk("rst_after_valid", valid, 0);
        chk("rst_after_done", done, 0);
        return;
      end
      if (b == inject_at) begin
        start = 1'b1;
        sel   = 2'($urandom);
        chars = {$urandom, $urandom};
      end
      stalls = (b == stall_at) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int c = 0; c < stalls; c++) begin
        ready = 1'b0;
        chk("hold_valid", valid, 1);
        chk("hold_rs", rs, exp_rs[b]);
        chk("hold_q", q, exp_q[b]);
        step();
        start = 1'b0;
      end
      ready = 1'b1;
      chk("byte_valid", valid, 1);
      chk("byte_rs", rs, exp_rs[b]);
      chk("byte_q", q, exp_q[b]);
      chk("byte_busy", busy, 1);
      chk("byte_done", done, 0);
      step();
      start = 1'b0;
      ready = 1'($urandom);
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", valid, 0);
    if (inject_done) start = 1'b1;
    step();
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_valid", valid, 0);
    chk("post_busy", busy, 0);
  endtask

  task automatic run_b(input logic [1:0] l, input logic [5:0] s);
    b_sel   = l;
    b_chars = s;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_ready = 1'b1;
    b_chars = 6'($urandom);
    chk("b_addr_valid", b_valid, 1);
    chk("b_addr_rs", b_rs, 0);
    chk("b_addr_q", b_q, ref_addr(int'(l), 4));
    step();
    chk("b_char_rs", b_rs, 1);
    chk("b_char_q", b_q, ref_char(s, 1'b1));
    step();
    chk("b_done", b_done, 1);
    chk("b_valid_end", b_valid, 0);
    b_ready = 1'b0;
    step();
    chk("b_done_clear", b_done, 0);
  endtask

  initial begin
    logic [5:0] sl [N];
    rst = 1'b1; start = 1'b0; ready = 1'b0; sel = 2'd0; chars = '0;
    b_start = 1'b0; b_ready = 1'b0; b_sel = 2'd0; b_chars = '0;
    step();
    step();
    chk("rst_valid", valid, 0);
    chk("rst_rs", rs, 0);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_b_valid", b_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ready = 1'($urandom);
      step();
      chk("idle_valid", valid, 0);
      chk("idle_busy", busy, 0);
    end

    sl = '{6'h01, 6'h02, 6'h30, 6'h03, 6'h04, 6'h20, 6'h11, 6'h20};
    run_a(2'd1, sl, -1, 0, 1'b0, -1, 1'b0, -1);
    run_a(2'd1, sl, 2, 3, 1'b0, -1, 1'b0, -1);
    run_a(2'd1, sl, -1, 0, 1'b0, 4, 1'b1, -1);

    sl = '{6'h00, 6'h0C, 6'h10, 6'h09, 6'h0A, 6'h2F, 6'h3C, 6'h01};
    run_a(2'd3, sl, -1, 0, 1'b1, -1, 1'b0, -1);
    run_a(2'd2, sl, -1, 0, 1'b0, -1, 1'b0, 4);
    run_a(2'd0, sl, -1, 0, 1'b0, -1, 1'b0, -1);

    run_b(2'd0, 6'h00);
    run_b(2'd2, 6'h0C);
    run_b(2'd3, 6'h10);
    run_b(2'd1, 6'h3A);

    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++) sl[k] = 6'($urandom);
      run_a(2'($urandom), sl, -1, 0, 1'b1, (r % 3 == 0) ? int'($urandom_range(1, N)) : -1,
            1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hd44780_line_sequencer.md
Name: hd44780_line_sequencer

Overview:
Parametrised successor to the single-byte HD44780 data formatter. On a start pulse it snapshots a full line of NUM_CHARS character slots and streams one set-DDRAM-address command followed by NUM_CHARS character bytes to the HD44780 driver. Transfer uses a valid/ready handshake. It sits between the clock/time-keeping logic and the HD44780 bus driver, replacing per-byte sequencing in the top level.

Parameters:
NUM_CHARS, 8, character slots per line; legal range 1..16.
START_COL, 0, DDRAM column of slot 0; NUM_CHARS+START_COL must be <= 16 (elaboration-time check; fail if violated).

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  one-cycle request to refresh a line
i_line_sel  in  2  target display line, 0..3
i_chars  in  6*NUM_CHARS  slot k = i_chars[6k+5:6k]; [5:4] kind, [3:0] payload; slot 0 is leftmost
i_ready  in  1  driver accepts current byte
o_valid  out  1  o_q/o_rs hold a byte for the driver
o_rs  out  1  0 = command byte, 1 = data byte
o_q  out  8  byte to driver
o_busy  out  1  sequence in progress
o_done  out  1  one-cycle pulse after final byte accepted

Behaviour:
- Reset: state IDLE; o_valid=0, o_rs=0, o_q=8'h00, o_busy=0, o_done=0; slot index=0; snapshot registers cleared. Reset mid-sequence aborts immediately; no further bytes are emitted.
- FSM states:
  - IDLE -> ADDR on i_start. i_line_sel and i_chars are latched the same edge; later input changes do not affect the sequence.
  - ADDR -> CHAR on handshake.
  - CHAR stays in CHAR while index < NUM_CHARS-1; index increments per handshake.
  - CHAR -> IDLE on handshake of the last slot.
- Handshake is o_valid && i_ready at a rising edge. While o_valid=1 and i_ready=0, o_q and o_rs are held stable. o_valid=1 in ADDR and CHAR only.
- Latency: i_start at edge N gives the address byte valid from cycle N+1. With i_ready tied high, one byte per cycle, NUM_CHARS+1 bytes total.
- o_busy=1 exactly while in ADDR or CHAR.
- o_done=1 for one cycle, the cycle after the last handshake, coincident with o_busy falling.
- Address byte: o_rs=0, o_q = 8'h80 | {sel[0],1'b0,sel[1],4'b0} + START_COL. Line bases are 0x80, 0xC0, 0x90, 0xD0 for lines 0..3.
- Character byte: o_rs=1, mapped from the slot kind:
  - 00 digit: 8'h30+payload for payload 0..9; payload 10..15 gives 8'h3F ('?').
  - 01 meridiem: payload[0]=1 gives 8'h50 'P', else 8'h41 'A'.
  - 10 blank: 8'h20.
  - 11 colon: 8'h3A.
- i_start while busy, including the o_done cycle, is ignored. It is neither queued nor able to corrupt the snapshot.
- i_ready asserted while o_valid=0 has no effect.
- NUM_CHARS=1: ADDR, then one CHAR, then IDLE.

Optional Feature:
HD44780_LEADING_BLANK_EN
- Defined: if slot 0 has kind 00 and payload 0, it is emitted as 8'h20 (blank hour tens, e.g. " 9:41"). All other slots are unchanged.
- Undefined: slot 0 digit 0 is emitted as 8'h30, like every other digit.

Test Plan:
- Reset then idle: i_rst high 2 cycles -> all outputs 0. No o_valid after release without i_start.
- NUM_CHARS=8, START_COL=0, line 1, slots "12:34 PM" with ready tied high -> bytes C0(rs0), 31,32,3A,33,34,20,50,4D? No: kind 01 yields only P/A, so use slots 1,2,colon,3,4,blank,meridiem(P),blank -> C0, 31,32,3A,33,34,20,50,20 on consecutive cycles. o_done in the cycle after the 0x20 handshake.
- Backpressure: i_ready low for 3 cycles on the third byte -> o_q=0x32 and o_rs=1 held stable, no skip or duplicate. Sequence resumes when i_ready returns high.
- Snapshot and start-while-busy: change i_chars and pulse i_start mid-sequence -> original bytes complete unchanged. Exactly one o_done; o_busy falls once.
- Address/mapping corners: lines 0/2/3 with START_COL=4 -> 0x84/0x94/0xD4. Digit payload 12 -> 0x3F; meridiem payload 0 -> 0x41.
- Reset mid-op, plus macro: i_rst asserted during the CHAR state -> o_valid=0 next cycle, then idle. With HD44780_LEADING_BLANK_EN, slot0 digit 0 -> 0x20; without the macro -> 0x30.
